// File: rtl/alimentador_instrucoes_if.sv
// alimentador_instrucoes_if: control, program-load and processor handshake signals of the instruction feeder
interface alimentador_instrucoes_if #(parameter int DEPTH = 32);
   localparam int ADDR_W = $clog2(DEPTH);
   logic Start, LoadEn, Done, Run, Busy, Halted, Error;
   logic [ADDR_W-1:0] LoadAddr, PC;
   logic [15:0] LoadData, DIN;
   logic [7:0] Retired;
   modport master (input Start, LoadEn, LoadAddr, LoadData, Done,
                   output DIN, Run, PC, Busy, Halted, Error, Retired);
   modport slave (output Start, LoadEn, LoadAddr, LoadData, Done,
                  input DIN, Run, PC, Busy, Halted, Error, Retired);
endinterface

// File: rtl/alimentador_instrucoes.sv
// alimentador_instrucoes: program memory that feeds processador_multiciclo one instruction at a time
module alimentador_instrucoes #(
   parameter int DEPTH = 32,
   parameter int TIMEOUT = 8
) (
   input logic Clock,
   input logic Reset,
   alimentador_instrucoes_if.master bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   typedef enum logic [2:0] {IDLE, FETCH, ISSUE, IMM, WAIT, HALT} state_t;
   state_t state, nxt;
   logic [15:0] mem [DEPTH];
   logic [15:0] immr, word;
   logic [CNT_W-1:0] cnt;
   logic [ADDR_W:0] next_pc;
   logic ready, sentinel, mvi_end, issue, retire, timeout, end_mem, ir_mvi;

   assign word = mem[bus.PC];
   assign ready = state == IDLE || state == HALT;
   assign sentinel = word == 16'hFFFF;
   // an mvi in the last word would need its immediate from beyond the memory
   assign mvi_end = state == FETCH && !sentinel && word[8:6] == 3'b001 && bus.PC == ADDR_W'(DEPTH - 1);
   assign issue = state == FETCH && !sentinel && !mvi_end;
   assign retire = (state == IMM || state == WAIT) && bus.Done;
   assign timeout = state == WAIT && !bus.Done && cnt == CNT_W'(TIMEOUT - 1);
   assign next_pc = {1'b0, bus.PC} + (ir_mvi ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1));
   assign end_mem = next_pc > (ADDR_W+1)'(DEPTH - 1);
   assign bus.Busy = !ready;
   assign bus.Halted = state == HALT;

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE, HALT: nxt = bus.Start ? FETCH : state;
         FETCH: nxt = issue ? ISSUE : HALT;
         ISSUE: nxt = ir_mvi ? IMM : WAIT;
         IMM, WAIT: nxt = retire ? (end_mem ? HALT : FETCH) : (timeout ? HALT : WAIT);
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clock) state <= Reset ? IDLE : nxt;

   always_ff @(posedge Clock)
      if (!Reset && ready && bus.LoadEn) mem[bus.LoadAddr] <= bus.LoadData;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         bus.PC <= '0;
         bus.DIN <= '0;
         bus.Run <= 1'b0;
         bus.Error <= 1'b0;
         bus.Retired <= '0;
         cnt <= '0;
         ir_mvi <= 1'b0;
         immr <= '0;
      end else begin
         bus.Run <= issue;
         if (ready && bus.Start) begin
            bus.PC <= '0;
            bus.Retired <= '0;
            bus.Error <= 1'b0;
         end
         if (issue) begin
            ir_mvi <= word[8:6] == 3'b001;
            immr <= mem[bus.PC + 1'b1];
            bus.DIN <= word;
         end
         if (state == ISSUE && ir_mvi) bus.DIN <= immr;
         if (mvi_end || timeout) bus.Error <= 1'b1;
         cnt <= state == ISSUE ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
         if (retire) begin
            bus.Retired <= bus.Retired + 1'b1;
            if (!end_mem) bus.PC <= next_pc[ADDR_W-1:0];
         end
      end
   end
endmodule

// File: tb/tb_alimentador_instrucoes.sv
// tb_alimentador_instrucoes: drives programs through the feeder against a program-level reference model
module tb_alimentador_instrucoes;
   localparam int D = 32, T = 8;
   logic Clock = 1'b0;
   logic Reset;
   alimentador_instrucoes_if #(.DEPTH(D)) bus ();
   alimentador_instrucoes #(.DEPTH(D), .TIMEOUT(T)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));
   always #5 Clock = ~Clock;

   logic [15:0] pm [D];
   int lat [64];
   logic [15:0] exp_q [$], got_q [$];
   int exp_pc, exp_ret, n_chk = 0, n_pass = 0;
   int n_runs = 0, run_base = 0, viol = 0, viol_base = 0, got_base = 0, cd = 0;
   bit exp_err, imm_next = 0, prev_run = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // reference: walk the program word by word using the instruction-level rules
   function automatic void model();
      int pc = 0, k = 0;
      logic [15:0] w;
      bit mvi;
      exp_q.delete();
      exp_ret = 0;
      exp_err = 0;
      for (int g = 0; g < D; g++) begin
         w = pm[pc];
         mvi = w[8:6] == 3'b001;
         if (w == 16'hFFFF) break;
         if (mvi && pc == D - 1) begin exp_err = 1; break; end
         exp_q.push_back(w);
         if (mvi) exp_q.push_back(pm[pc + 1]);
         if (lat[k] > T + int'(mvi)) begin exp_err = 1; break; end
         k++;
         exp_ret++;
         if (pc + (mvi ? 2 : 1) > D - 1) break;
         pc += mvi ? 2 : 1;
      end
      exp_pc = pc;
   endfunction

   // processor stub answers each Run with Done after lat[] cycles; also records what was issued
   always @(negedge Clock) begin
      if (imm_next) begin
         got_q.push_back(bus.DIN);
         if (bus.Run) viol++;
      end
      imm_next = bus.Run && bus.DIN[8:6] == 3'b001;
      if (bus.Run) begin
         got_q.push_back(bus.DIN);
         if (prev_run) viol++;
         cd = lat[(n_runs - run_base) % 64];
         n_runs++;
         bus.Done = 1'b0;
      end else if (cd > 0) begin
         cd--;
         bus.Done = cd == 0;
      end else bus.Done = 1'b0;
      prev_run = bus.Run;
   end

   task automatic load(input int a, input logic [15:0] d);
      bus.LoadEn = 1'b1;
      bus.LoadAddr = 5'(a);
      bus.LoadData = d;
      @(negedge Clock);
      bus.LoadEn = 1'b0;
   endtask

   task automatic put(input int a, input logic [15:0] d);
      pm[a] = d;
      load(a, d);
   endtask

   task automatic fill_lat(input int v);
      for (int i = 0; i < 64; i++) lat[i] = v;
   endtask

   task automatic start_prog(input string tag);
      model();
      run_base = n_runs;
      viol_base = viol;
      got_base = got_q.size();
      bus.Start = 1'b1;
      @(negedge Clock);
      bus.Start = 1'b0;
      check({tag, "_fetch_busy"}, 32'(bus.Busy), 32'(1));
      check({tag, "_fetch_run"}, 32'(bus.Run), 32'(0));
      @(negedge Clock);
      check({tag, "_first_run"}, 32'(bus.Run), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) check({tag, "_first_din"}, 32'(bus.DIN), 32'(exp_q[0]));
   endtask

   task automatic finish_prog(input string tag, output int w);
      w = 0;
      while (!bus.Halted && w < 2000) begin
         @(negedge Clock);
         w++;
      end
      check({tag, "_halted"}, 32'(bus.Halted), 32'(1));
      check({tag, "_busy"}, 32'(bus.Busy), 32'(0));
      check({tag, "_pc"}, 32'(bus.PC), 32'(exp_pc));
      check({tag, "_retired"}, 32'(bus.Retired), 32'(exp_ret % 256));
      check({tag, "_error"}, 32'(bus.Error), 32'(exp_err));
      check({tag, "_issued"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
      foreach (exp_q[i])
         if (got_base + i < got_q.size()) check({tag, "_din"}, 32'(got_q[got_base + i]), 32'(exp_q[i]));
      check({tag, "_run_shape"}, 32'(viol - viol_base), 32'(0));
      repeat (T + 4) @(negedge Clock);
   endtask

   task automatic run(input string tag);
      int w;
      start_prog(tag);
      finish_prog(tag, w);
   endtask

   function automatic logic [15:0] rand_word();
      int r = $urandom_range(0, 39);
      return r == 0 ? 16'hFFFF : r < 8 ? {7'b0, 3'b001, 6'($urandom)} : r == 8 ? 16'($urandom) : {7'b0, 9'($urandom)};
   endfunction

   initial begin
      int w;
      Reset = 1'b1;
      bus.Start = 1'b0;
      bus.LoadEn = 1'b0;
      bus.LoadAddr = '0;
      bus.LoadData = '0;
      repeat (3) @(negedge Clock);
      check("rst_din", 32'(bus.DIN), 32'(0));
      check("rst_run", 32'(bus.Run), 32'(0));
      check("rst_pc", 32'(bus.PC), 32'(0));
      check("rst_flags", {29'(0), bus.Busy, bus.Halted, bus.Error}, 32'(0));
      check("rst_retired", 32'(bus.Retired), 32'(0));
      Reset = 1'b0;
      for (int i = 0; i < D; i++) put(i, 16'hFFFF);
      fill_lat(2);
      put(0, 16'h0001);
      run("mv");
      put(0, 16'h0040); put(1, 16'h002A); put(2, 16'hFFFF);
      run("mvi");
      put(0, 16'h0001); put(1, 16'hFFFF);
      fill_lat(T);
      run("lat_max");
      fill_lat(T + 1);
      start_prog("timeout");
      finish_prog("timeout", w);
      check("timeout_cycles", 32'(w), 32'(T + 1));
      put(0, 16'h0040); put(1, 16'h0005); put(2, 16'hFFFF);
      run("mvi_lat_max");
      fill_lat(T + 2);
      start_prog("mvi_timeout");
      finish_prog("mvi_timeout", w);
      check("mvi_timeout_cycles", 32'(w), 32'(T + 2));
      for (int i = 0; i < D; i++) put(i, 16'h0001);
      fill_lat(1);
      run("end_mem");
      put(31, 16'h0040);
      run("end_mvi");
      // reset while the third word waits for Done
      for (int i = 0; i < D; i++) put(i, 16'hFFFF);
      put(0, 16'h0040); put(1, 16'h002A); put(2, 16'h0001);
      fill_lat(4);
      start_prog("pre_rst");
      w = 0;
      while (!(bus.Run && bus.PC == 5'd2) && w < 100) begin
         @(negedge Clock);
         w++;
      end
      @(negedge Clock);
      check("pre_rst_busy", 32'(bus.Busy), 32'(1));
      Reset = 1'b1;
      @(negedge Clock);
      check("mid_rst_run", 32'(bus.Run), 32'(0));
      check("mid_rst_din", 32'(bus.DIN), 32'(0));
      check("mid_rst_pc", 32'(bus.PC), 32'(0));
      check("mid_rst_busy", 32'(bus.Busy), 32'(0));
      Reset = 1'b0;
      repeat (T + 4) @(negedge Clock);
      run("rerun");
      put(0, 16'h0001); put(1, 16'h0002); put(2, 16'hFFFF);
      fill_lat(6);
      start_prog("busy_load");
      @(negedge Clock);
      load(1, 16'h0009);
      finish_prog("busy_load", w);
      put(1, 16'h0009);
      run("halt_load");
      for (int t = 0; t < 25; t++) begin
         for (int i = 0; i < D; i++) put(i, rand_word());
         for (int i = 0; i < 64; i++)
            lat[i] = $urandom_range(0, 9) == 0 ? $urandom_range(T - 1, T + 2) : $urandom_range(1, 4);
         run($sformatf("rnd%0d", t));
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/alimentador_instrucoes.md
# alimentador_instrucoes

Instruction feeder that sits directly upstream of `processador_multiciclo`. It holds a small program memory and presents each instruction on the processor's `DIN` with a one-cycle `Run` pulse, then supplies the immediate word for `mvi`. It waits for the processor's `Done` before advancing. It turns the processor into a self-running system for simulation and for the FPGA board, replacing hand-driven `DIN`/`Run` stimulus.

## Interface
- `DEPTH`, 32: program memory words; PC width `ADDR_W` = $clog2(DEPTH).
- `TIMEOUT`, 8: maximum cycles spent waiting for `Done` after `Run`.
- `Clock`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  reset, synchronous, active-high.
- `Start`  in  1  begin execution from address 0; honoured only in IDLE or HALT.
- `LoadEn`  in  1  program-memory write strobe; honoured only in IDLE or HALT.
- `LoadAddr`  in  ADDR_W  write address.
- `LoadData`  in  16  write data.
- `Done`  in  1  from processor; instruction completed.
- `DIN`  out  16  to processor data input.
- `Run`  out  1  to processor; one-cycle pulse per instruction.
- `PC`  out  ADDR_W  address of the instruction currently issued or fetched.
- `Busy`  out  1  high in FETCH, ISSUE, IMM and WAIT.
- `Halted`  out  1  high in HALT.
- `Error`  out  1  sticky fault flag; cleared by Start or Reset.
- `Retired`  out  8  count of completed instructions; wraps modulo 256.

## Operation
- Memory: DEPTH x 16 register array with asynchronous read and synchronous write. Not cleared by Reset.
- Instruction format: `DIN[8:6]` = opcode, `[5:3]` = Rx, `[2:0]` = Ry, `[15:9]` = 0. Opcode 3'b001 = `mvi`, which is followed by one immediate word. Word 16'hFFFF is the halt sentinel.
- States: IDLE, FETCH, ISSUE, IMM, WAIT, HALT.
- IDLE/HALT, on Start:
  - PC←0, Retired←0, Error←0, go to FETCH.
  - If LoadEn is asserted in the same cycle, the write is performed as well.
- FETCH:
  - If mem[PC] = 16'hFFFF, go to HALT.
  - Else if opcode = `mvi` and PC = DEPTH-1, set Error and go to HALT.
  - Otherwise IR←mem[PC], IMMR←mem[PC+1], go to ISSUE.
- ISSUE (exactly one cycle): DIN=IR, Run=1. Go to IMM if `mvi`, else WAIT. Clear the timeout counter.
- IMM (one cycle): DIN=IMMR, Run=0. Done is sampled here; if high, retire. Otherwise go to WAIT.
- WAIT: DIN holds its last value, Run=0, the timeout counter increments each cycle.
  - On Done, retire.
  - When the counter reaches TIMEOUT without Done, set Error and go to HALT; PC is unchanged.
- Retire:
  - Retired+1.
  - Next = PC+2 for `mvi`, PC+1 otherwise.
  - If next > DEPTH-1, PC holds its current value and go to HALT (end of memory). Otherwise PC←next, go to FETCH.
- Done is ignored in IDLE, FETCH, ISSUE and HALT.
- LoadEn is ignored in all states except IDLE and HALT.
- Reset takes priority over everything, including mid-instruction:
  - State←IDLE, PC←0, DIN←0, Run←0, Error←0, Retired←0, counter←0.
  - Memory contents are kept.
- All outputs are registered except Busy and Halted, which decode the state register.

## Timing
- Reset values: DIN=16'h0000, Run=0, PC=0, Busy=0, Halted=0, Error=0, Retired=0.
- Start sampled at edge k: FETCH in cycle k+1, Run=1 with DIN=instruction in cycle k+2 (processor T0).
- Non-mvi: processor completes in T1 or later, so Done is seen in WAIT.
- `mvi`: immediate is on DIN in the cycle after Run (processor T1), which is where the processor reads it.
- Done sampled at edge m: FETCH in cycle m+1, next Run in cycle m+2. Minimum issue spacing is 3 cycles.
- Run is never high in two consecutive cycles.
- Error and Halted assert the cycle after the offending FETCH or timeout edge.

## Test plan
- **Single mv:** mem[0]=16'h0001 (mv R0,R1), mem[1]=16'hFFFF, R1=10; Start → Run high exactly one cycle with DIN=16'h0001 two cycles after Start. Then R0=10, PC=1, Retired=1, Halted=1, Busy=0, Error=0.
- **mvi:** mem[0]=16'h0040, mem[1]=16'h002A, mem[2]=16'hFFFF → DIN=16'h0040 with Run=1, then DIN=16'h002A with Run=0 the next cycle. Then R0=42, PC=2, Retired=1, Halted=1.
- **Timeout:** processor stubbed with Done tied 0, mem[0]=16'h0001 → Error=1 and Halted=1 after TIMEOUT wait cycles. PC=0, Retired=0.
- **End of memory:** all 32 words = 16'h0001, no sentinel → Retired=32, PC=31, Halted=1, Error=0. Then rerun with mem[31]=16'h0040 → Error=1 at PC=31.
- **Reset mid-instruction:** Reset asserted in WAIT → next cycle Run=0, DIN=0, PC=0, Busy=0. A subsequent Start reruns the program with identical results.
- **Load while busy:** LoadEn to address 1 during WAIT is ignored; mem[1] is unchanged. The same write in HALT takes effect, and the next Start executes the new word.
